led_pwm_fader: RTL and testbench
================================

// Module: led_pwm_fader
// PURPOSE
//   Downstream stage of the water-LED pattern generator. Takes its on/off targets and outputs PWM-dimmed drive:
//   8 single LEDs (led) and 4 RGB LEDs (ld1..ld4, 3 bits each), 20 channels in total.
//   Each channel ramps its brightness toward its target, so pattern steps cross-fade instead of hard-switching.
//   Outputs go directly to the LED pins.
// PARAMETERS
//   PRESCALE   16          clk cycles per PWM count step (>=1)
//   PWM_BITS   8           PWM counter/level width; MAX = 2**PWM_BITS-1
//   FADE_DIV   4           PWM periods between level updates (>=1)
//   STEP       8           level change per update (1..MAX)
//   OUT_INV    20'h0_0000  per-channel output inversion mask, bit order = channel index
// PORTS
//   clk       in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   en        in   1   fader enable; 0 = all channels off, counters cleared
//   led_in    in   8   target pattern, single LEDs (1 = on)
//   ld1_in    in   3   target pattern, RGB LED 1
//   ld2_in    in   3   target pattern, RGB LED 2
//   ld3_in    in   3   target pattern, RGB LED 3
//   ld4_in    in   3   target pattern, RGB LED 4
//   led_out   out  8   PWM drive, single LEDs
//   ld1_out   out  3   PWM drive, RGB LED 1 (ld2_out..ld4_out identical, 3 bits each)
//   busy      out  1   1 while any channel level differs from its target endpoint
// BEHAVIOUR
//   - Channel map: ch[7:0]=led_in, ch[10:8]=ld1_in, ch[13:11]=ld2_in, ch[16:14]=ld3_in, ch[19:17]=ld4_in.
//     The same map applies to the outputs and to OUT_INV.
//   - Reset, asynchronous: prescaler, pwm_cnt, fade_cnt, tgt[19:0] and level[*] all 0.
//     Outputs at reset = OUT_INV bits (off); busy = 0.
//   - Targets: tgt <= {ld4_in,ld3_in,ld2_in,ld1_in,led_in} every clk (1-cycle register). Inputs are synchronous to clk.
//   - Prescaler: pre_cnt runs 0..PRESCALE-1. tick = (pre_cnt==PRESCALE-1). PRESCALE=1 gives tick every cycle.
//   - pwm_cnt (PWM_BITS wide) increments on tick and wraps MAX->0.
//     period_end = tick && pwm_cnt==MAX.
//   - fade_cnt runs 0..FADE_DIV-1 and advances on period_end.
//     fade_tick = period_end && fade_cnt==FADE_DIV-1.
//   - On fade_tick, per channel, using PWM_BITS+1-bit arithmetic with saturation:
//     tgt=1: level <= min(level+STEP, MAX); tgt=0: level <= (level<STEP) ? 0 : level-STEP.
//   - Duty changes only on a period boundary, so no partial-period glitch is allowed.
//   - Target reversal mid-ramp: the ramp continues from the current level in the new direction at the next fade_tick.
//     There is no restart from 0 or MAX.
//   - Output, registered with 1 clk latency from pwm_cnt/level:
//     on = (level==MAX) | (pwm_cnt < level); out = on ^ OUT_INV[ch].
//     level=0 -> never on. level=MAX -> constantly on, with no off-slot.
//   - busy (registered) = OR over ch of (level != (tgt ? MAX : 0)).
//   - en=0, synchronous: pre_cnt, pwm_cnt, fade_cnt and all levels cleared to 0; outputs = OUT_INV; busy = 0.
//     tgt keeps sampling. On en 0->1, channels with tgt=1 ramp up from 0 starting at the first fade_tick.
//   - Reset asserted mid-ramp: everything returns immediately to reset values. No fade-out.
// STRUCTURE
//   - Shared package led_pkg: NUM_CH=20, channel-index constants (CH_LED0=0, CH_LD1=8, CH_LD2=11, CH_LD3=14, CH_LD4=17),
//     and function sat_step(level, dir, STEP, MAX).
//   - Top level: prescaler/pwm_cnt/fade_cnt timebase, target register, busy reduction.
//   - Sub-module led_fade_channel, generated NUM_CH times.
//     Ports: clk, rst_n, clr, fade_tick, tgt, pwm_cnt, inv -> out, at_target.
//     Holds one level register plus the output flop.
// TESTING (PRESCALE=1, PWM_BITS=4 so MAX=15, FADE_DIV=1, STEP=4 unless stated)
//   1. Reset, en=1, led_in=8'h01 -> level[0] steps 4,8,12,15 at successive period ends (every 16 clk).
//      Duty ch0 = 4/16, 8/16, 12/16, then constantly high. busy drops in the cycle after level reaches 15.
//   2. From ch0 at 15, set led_in=0 -> levels 11,7,3,0; led_out[0] constantly low at 0; busy 1 -> 0.
//   3. Reversal: ch0 at 8 rising, drop led_in[0] before the next fade_tick -> next level 4, not 12.
//      Duty updates only at pwm_cnt wrap.
//   4. OUT_INV=20'hE0000, ld4_in=3'b000 -> ld4_out=3'b111 out of reset and during en=0.
//      With ld4_in=3'b111, ld4_out fades toward 3'b000 (inverted PWM).
//   5. PRESCALE=3, FADE_DIV=2 -> period = 48 clk, level update every 96 clk.
//      Check the tick spacing and the level update spacing exactly.
//   6. Async rst_n pulse (mid-cycle, <1 clk) during a ramp -> outputs = OUT_INV and levels 0 immediately.
//      After release the ramp resumes from 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader: channel count, channel index map
// and the saturating level-step helper used by every fade channel.
package led_pkg;

    localparam int NUM_CH  = 20;
    localparam int CH_LED0 = 0;
    localparam int CH_LD1  = 8;
    localparam int CH_LD2  = 11;
    localparam int CH_LD3  = 14;
    localparam int CH_LD4  = 17;

    // One brightness step toward MAX (dir=1) or toward 0 (dir=0), clamped at
    // both ends. 17-bit operands leave headroom for level+step up to 16-bit levels.
    function automatic logic [16:0] sat_step(
        input logic [16:0] level,
        input logic        dir,
        input logic [16:0] step,
        input logic [16:0] max
    );
        logic [16:0] sum_s;
        logic [16:0] res_s;
        sum_s = level + step;
        if (dir) begin
            if (sum_s > max) begin
                res_s = max;
            end else begin
                res_s = sum_s;
            end
        end else begin
            if (level < step) begin
                res_s = 17'd0;
            end else begin
                res_s = level - step;
            end
        end
        return res_s;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One fader channel: a brightness level that ramps toward its on/off target on
// each fade tick, and the registered PWM comparator that drives the pin.
module led_fade_channel #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                fade_tick,
    input  logic                tgt,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                inv,
    output logic                out,
    output logic                at_target
);
    import led_pkg::*;

    localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO_LVL = {PWM_BITS{1'b0}};
    localparam logic [16:0]         STEP_W   = 17'(STEP);
    localparam logic [16:0]         MAX_W    = 17'(MAX_LVL);

    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] level_nxt_s;
    logic                on_s;
    logic                on_r;

    assign level_nxt_s = PWM_BITS'(sat_step(17'(level_r), tgt, STEP_W, MAX_W));

    // Full level means no off-slot at all; otherwise on for the first 'level' counts.
    assign on_s = (level_r == MAX_LVL) | (pwm_cnt < level_r);

    assign at_target = (level_r == (tgt ? MAX_LVL : ZERO_LVL));

    // Inversion mask is a static tie-off, so the XOR after the flop cannot glitch.
    assign out = on_r ^ inv;

    // Brightness level: moves one saturating step only on fade ticks, which sit on
    // PWM period boundaries, so a reversal simply continues from the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= ZERO_LVL;
        end else if (clr) begin
            level_r <= ZERO_LVL;
        end else if (fade_tick) begin
            level_r <= level_nxt_s;
        end else begin
            level_r <= level_r;
        end
    end

    // Registered PWM comparator, one clock behind pwm_cnt/level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_r <= 1'b0;
        end else if (clr) begin
            on_r <= 1'b0;
        end else begin
            on_r <= on_s;
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// PWM cross-fader for the water-LED pattern: 8 single LEDs plus 4 RGB LEDs
// (20 channels) each ramp toward their on/off target. Shared timebase,
// target register and busy flag live here; per-channel state in led_fade_channel.
module led_pwm_fader #(
    parameter int          PRESCALE = 16,
    parameter int          PWM_BITS = 8,
    parameter int          FADE_DIV = 4,
    parameter int          STEP     = 8,
    parameter logic [19:0] OUT_INV  = 20'h0_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] led_in,
    input  logic [2:0] ld1_in,
    input  logic [2:0] ld2_in,
    input  logic [2:0] ld3_in,
    input  logic [2:0] ld4_in,
    output logic [7:0] led_out,
    output logic [2:0] ld1_out,
    output logic [2:0] ld2_out,
    output logic [2:0] ld3_out,
    output logic [2:0] ld4_out,
    output logic       busy
);
    import led_pkg::*;

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LVL = {PWM_BITS{1'b1}};

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [FADE_W-1:0]   fade_cnt_r;
    logic [NUM_CH-1:0]   tgt_r;
    logic [NUM_CH-1:0]   chan_out_s;
    logic [NUM_CH-1:0]   at_target_s;
    logic                busy_r;
    logic                clr_s;
    logic                tick_s;
    logic                period_end_s;
    logic                fade_tick_s;

    assign clr_s        = ~en;
    assign tick_s       = (pre_cnt_r == PRE_W'(PRESCALE - 1));
    assign period_end_s = tick_s & (pwm_cnt_r == MAX_LVL);
    assign fade_tick_s  = period_end_s & (fade_cnt_r == FADE_W'(FADE_DIV - 1));

    // Prescaler: one PWM count step every PRESCALE clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (clr_s || tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
        end
    end

    // PWM counter, wraps MAX->0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else if (clr_s) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Fade divider: counts PWM periods between level updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt_r <= {FADE_W{1'b0}};
        end else if (clr_s || fade_tick_s) begin
            fade_cnt_r <= {FADE_W{1'b0}};
        end else if (period_end_s) begin
            fade_cnt_r <= fade_cnt_r + FADE_W'(1'b1);
        end else begin
            fade_cnt_r <= fade_cnt_r;
        end
    end

    // Target register keeps sampling even while disabled so a re-enable starts
    // from the current pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r <= {NUM_CH{1'b0}};
        end else begin
            tgt_r <= {ld4_in, ld3_in, ld2_in, ld1_in, led_in};
        end
    end

    // Busy while any channel is still short of its endpoint; forced idle when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else if (clr_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= ~(&at_target_s);
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr_s),
            .fade_tick (fade_tick_s),
            .tgt       (tgt_r[ch]),
            .pwm_cnt   (pwm_cnt_r),
            .inv       (OUT_INV[ch]),
            .out       (chan_out_s[ch]),
            .at_target (at_target_s[ch])
        );
    end

    assign led_out = chan_out_s[CH_LD1-1:CH_LED0];
    assign ld1_out = chan_out_s[CH_LD2-1:CH_LD1];
    assign ld2_out = chan_out_s[CH_LD3-1:CH_LD2];
    assign ld3_out = chan_out_s[CH_LD4-1:CH_LD3];
    assign ld4_out = chan_out_s[NUM_CH-1:CH_LD4];
    assign busy    = busy_r;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two instances (fast timebase with RGB LED 4 inverted,
// and PRESCALE=3/FADE_DIV=2) sharing stimulus, checked against a per-cycle
// arithmetic reference model plus explicit duty-cycle expectations.
module tb_led_pwm_fader;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] led_in;
    logic [2:0] ld1_in, ld2_in, ld3_in, ld4_in;

    logic [7:0] led_out_a, led_out_b;
    logic [2:0] ld1_out_a, ld2_out_a, ld3_out_a, ld4_out_a;
    logic [2:0] ld1_out_b, ld2_out_b, ld3_out_b, ld4_out_b;
    logic       busy_a, busy_b;
    logic [19:0] out_a_s, out_b_s;

    int n_chk;
    int n_fail;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int          m_n [2];
    int          m_lvl [2][20];
    logic [19:0] m_out [2];
    logic        m_busy [2];
    logic [19:0] m_tgt;

    led_pwm_fader #(.PRESCALE(1), .PWM_BITS(4), .FADE_DIV(1), .STEP(4), .OUT_INV(20'hE0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .led_in(led_in),
        .ld1_in(ld1_in), .ld2_in(ld2_in), .ld3_in(ld3_in), .ld4_in(ld4_in),
        .led_out(led_out_a), .ld1_out(ld1_out_a), .ld2_out(ld2_out_a),
        .ld3_out(ld3_out_a), .ld4_out(ld4_out_a), .busy(busy_a)
    );

    led_pwm_fader #(.PRESCALE(3), .PWM_BITS(4), .FADE_DIV(2), .STEP(4), .OUT_INV(20'h00000)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .led_in(led_in),
        .ld1_in(ld1_in), .ld2_in(ld2_in), .ld3_in(ld3_in), .ld4_in(ld4_in),
        .led_out(led_out_b), .ld1_out(ld1_out_b), .ld2_out(ld2_out_b),
        .ld3_out(ld3_out_b), .ld4_out(ld4_out_b), .busy(busy_b)
    );

    assign out_a_s = {ld4_out_a, ld3_out_a, ld2_out_a, ld1_out_a, led_out_a};
    assign out_b_s = {ld4_out_b, ld3_out_b, ld2_out_b, ld1_out_b, led_out_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pre_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int upd_of(int d);
        return (d == 0) ? 16 : 3 * 16 * 2;
    endfunction

    function automatic bit inv_bit(int d, int c);
        return (d == 0) && (c >= 17);
    endfunction

    function automatic bit model_on(int lvl, int pwm);
        return (lvl == 15) || (pwm < lvl);
    endfunction

    function automatic int next_lvl(int lvl, bit t);
        if (t) return (lvl + 4 > 15) ? 15 : lvl + 4;
        else   return (lvl < 4) ? 0 : lvl - 4;
    endfunction

    function automatic bit model_busy(int d);
        bit b;
        b = 1'b0;
        for (int c = 0; c < 20; c++)
            if (m_lvl[d][c] != (m_tgt[c] ? 15 : 0)) b = 1'b1;
        return b;
    endfunction

    // Reference model: time since last clear gives the PWM count and fade instants.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tgt <= 20'h0;
            for (int d = 0; d < 2; d++) begin
                m_n[d]    <= 0;
                m_busy[d] <= 1'b0;
                m_out[d]  <= (d == 0) ? 20'hE0000 : 20'h00000;
                for (int c = 0; c < 20; c++) m_lvl[d][c] <= 0;
            end
        end else begin
            m_tgt <= {ld4_in, ld3_in, ld2_in, ld1_in, led_in};
            for (int d = 0; d < 2; d++) begin
                if (!en) begin
                    m_n[d]    <= 0;
                    m_busy[d] <= 1'b0;
                    m_out[d]  <= (d == 0) ? 20'hE0000 : 20'h00000;
                    for (int c = 0; c < 20; c++) m_lvl[d][c] <= 0;
                end else begin
                    m_n[d]    <= m_n[d] + 1;
                    m_busy[d] <= model_busy(d);
                    for (int c = 0; c < 20; c++) begin
                        m_out[d][c] <= model_on(m_lvl[d][c], (m_n[d] / pre_of(d)) % 16) ^ inv_bit(d, c);
                        if ((m_n[d] + 1) % upd_of(d) == 0)
                            m_lvl[d][c] <= next_lvl(m_lvl[d][c], m_tgt[c]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        led_in = 8'h00; ld1_in = 3'b000; ld2_in = 3'b000; ld3_in = 3'b000; ld4_in = 3'b000;
        repeat (3) @(negedge clk);
        n_chk++;
        if (out_a_s !== 20'hE0000 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_a: out=%h busy=%b expected out=e0000 busy=0", out_a_s, busy_a);
        end
        n_chk++;
        if (out_b_s !== 20'h00000 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: out=%h busy=%b expected out=00000 busy=0", out_b_s, busy_b);
        end
    endtask

    task automatic test_ramp_up();
        int exp_d[6];
        int cnt;
        exp_d = '{0, 4, 8, 12, 16, 16};
        @(negedge clk);
        led_in = 8'h01; en = 1'b1; rst_n = 1'b1;
        for (int p = 0; p < 6; p++) begin
            cnt = 0;
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                cnt += int'(led_out_a[0]);
                n_chk++;
                if (out_a_s !== m_out[0] || busy_a !== m_busy[0]) begin
                    n_fail++; $display("FAIL ramp_up_cycle: out=%h busy=%b expected out=%h busy=%b", out_a_s, busy_a, m_out[0], m_busy[0]);
                end
                if (p == 3 && s == 15) begin
                    n_chk++;
                    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ramp_up_busy_hold: busy=%b expected 1", busy_a); end
                end
                if (p == 4 && s == 0) begin
                    n_chk++;
                    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ramp_up_busy_drop: busy=%b expected 0", busy_a); end
                end
            end
            n_chk++;
            if (cnt != exp_d[p]) begin n_fail++; $display("FAIL ramp_up_duty p%0d: high=%0d expected %0d", p, cnt, exp_d[p]); end
        end
    endtask

    task automatic test_ramp_down();
        int exp_d[6];
        int cnt;
        exp_d = '{16, 11, 7, 3, 0, 0};
        led_in = 8'h00;
        for (int p = 0; p < 6; p++) begin
            cnt = 0;
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                cnt += int'(led_out_a[0]);
                n_chk++;
                if (out_a_s !== m_out[0] || busy_a !== m_busy[0]) begin
                    n_fail++; $display("FAIL ramp_down_cycle: out=%h busy=%b expected out=%h busy=%b", out_a_s, busy_a, m_out[0], m_busy[0]);
                end
                if (p == 3 && s == 15) begin
                    n_chk++;
                    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ramp_down_busy_hold: busy=%b expected 1", busy_a); end
                end
                if (p == 4 && s == 0) begin
                    n_chk++;
                    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ramp_down_busy_drop: busy=%b expected 0", busy_a); end
                end
            end
            n_chk++;
            if (cnt != exp_d[p]) begin n_fail++; $display("FAIL ramp_down_duty p%0d: high=%0d expected %0d", p, cnt, exp_d[p]); end
        end
    endtask

    task automatic test_reversal();
        int exp_d[4];
        int cnt;
        exp_d = '{0, 4, 8, 4};
        led_in = 8'h01;
        for (int p = 0; p < 4; p++) begin
            cnt = 0;
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                cnt += int'(led_out_a[0]);
                n_chk++;
                if (out_a_s !== m_out[0]) begin
                    n_fail++; $display("FAIL reversal_cycle: out=%h expected %h", out_a_s, m_out[0]);
                end
                if (p == 2 && s == 5) led_in = 8'h00;
            end
            n_chk++;
            if (cnt != exp_d[p]) begin n_fail++; $display("FAIL reversal_duty p%0d: high=%0d expected %0d", p, cnt, exp_d[p]); end
        end
    endtask

    task automatic test_inversion();
        int exp_low[6];
        int cnt;
        exp_low = '{0, 4, 8, 12, 16, 16};
        @(negedge clk);
        en = 1'b0; led_in = 8'h00; ld4_in = 3'b000;
        repeat (2) @(negedge clk);
        n_chk++;
        if (ld4_out_a !== 3'b111 || led_out_a !== 8'h00 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL inv_disabled: ld4=%b led=%h busy=%b expected ld4=111 led=00 busy=0", ld4_out_a, led_out_a, busy_a);
        end
        ld4_in = 3'b111; en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            cnt = 0;
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                cnt += int'(!ld4_out_a[0]);
                n_chk++;
                if (out_a_s !== m_out[0] || busy_a !== m_busy[0]) begin
                    n_fail++; $display("FAIL inv_cycle: out=%h busy=%b expected out=%h busy=%b", out_a_s, busy_a, m_out[0], m_busy[0]);
                end
            end
            n_chk++;
            if (cnt != exp_low[p]) begin n_fail++; $display("FAIL inv_duty p%0d: low=%0d expected %0d", p, cnt, exp_low[p]); end
        end
        n_chk++;
        if (ld4_out_a !== 3'b000) begin n_fail++; $display("FAIL inv_full: ld4=%b expected 000", ld4_out_a); end
        en = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ld4_out_a !== 3'b111 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL inv_reclear: ld4=%b busy=%b expected ld4=111 busy=0", ld4_out_a, busy_a);
        end
    endtask

    task automatic test_prescale();
        int exp_d[6];
        int cnt;
        int first_low;
        exp_d = '{0, 0, 12, 12, 24, 24};
        @(negedge clk);
        en = 1'b0; ld4_in = 3'b000; led_in = 8'h01;
        @(negedge clk);
        en = 1'b1;
        for (int p = 0; p < 6; p++) begin
            cnt = 0;
            first_low = -1;
            for (int s = 0; s < 48; s++) begin
                @(negedge clk);
                cnt += int'(led_out_b[0]);
                if (!led_out_b[0] && first_low < 0) first_low = s;
                n_chk++;
                if (out_b_s !== m_out[1] || busy_b !== m_busy[1]) begin
                    n_fail++; $display("FAIL prescale_cycle: out=%h busy=%b expected out=%h busy=%b", out_b_s, busy_b, m_out[1], m_busy[1]);
                end
            end
            n_chk++;
            if (cnt != exp_d[p]) begin n_fail++; $display("FAIL prescale_duty p%0d: high=%0d expected %0d", p, cnt, exp_d[p]); end
            if (p == 2) begin
                n_chk++;
                if (first_low != 12) begin n_fail++; $display("FAIL prescale_tick_pos: first_low=%0d expected 12", first_low); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_a_s !== m_out[0] || busy_a !== m_busy[0] || out_b_s !== m_out[1] || busy_b !== m_busy[1]) begin
                n_fail++;
                $display("FAIL random_cycle %0d: a=%h/%b b=%h/%b expected a=%h/%b b=%h/%b", i,
                         out_a_s, busy_a, out_b_s, busy_b, m_out[0], m_busy[0], m_out[1], m_busy[1]);
            end
            if ($urandom_range(0, 15) == 0)
                {ld4_in, ld3_in, ld2_in, ld1_in, led_in} = 20'($urandom);
            if ($urandom_range(0, 99) < 2) en = ~en;
        end
    endtask

    task automatic test_async_reset();
        int exp_d[2];
        int cnt;
        exp_d = '{0, 4};
        @(negedge clk);
        en = 1'b1; led_in = 8'hFF; ld1_in = 3'b111; ld2_in = 3'b111; ld3_in = 3'b111; ld4_in = 3'b111;
        repeat (40) begin
            @(negedge clk);
            n_chk++;
            if (out_a_s !== m_out[0] || out_b_s !== m_out[1]) begin
                n_fail++; $display("FAIL pre_reset_cycle: a=%h b=%h expected a=%h b=%h", out_a_s, out_b_s, m_out[0], m_out[1]);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_a_s !== 20'hE0000 || out_b_s !== 20'h00000 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: a=%h b=%h busy=%b%b expected a=e0000 b=00000 busy=00", out_a_s, out_b_s, busy_a, busy_b);
        end
        #1 rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            cnt = 0;
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                cnt += int'(led_out_a[0]);
                n_chk++;
                if (out_a_s !== m_out[0] || out_b_s !== m_out[1]) begin
                    n_fail++; $display("FAIL post_reset_cycle: a=%h b=%h expected a=%h b=%h", out_a_s, out_b_s, m_out[0], m_out[1]);
                end
            end
            n_chk++;
            if (cnt != exp_d[p]) begin n_fail++; $display("FAIL post_reset_duty p%0d: high=%0d expected %0d", p, cnt, exp_d[p]); end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_inversion();
        test_prescale();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
